std_cache_axi_limiter: RTL

- Sits directly downstream of the cache subsystem's merged AXI master port, between it and the SoC interconnect.
- Passes all five AXI channels through unchanged, except that it gates AR and AW.
- Bounds outstanding read and write transactions and provides a drain handshake so the core can quiesce the bus for fence or flush.
- Runs a response watchdog that flags a hung interconnect.

---
 rtl/ariane_axi_pkg.sv | 53 +++++
 rtl/std_cache_axi_limiter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/ariane_axi_pkg.sv
// AXI request/response bundles for the cache subsystem's merged master port.
package ariane_axi_pkg;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [3:0]  cache;
    logic [2:0]  prot;
  } ax_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } m_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } m_resp_t;

endpackage

// File: rtl/std_cache_axi_limiter.sv
// Outstanding-transaction limiter between the cache AXI master and the interconnect,
// with a drain handshake for fence/flush and a sticky response watchdog.
module std_cache_axi_limiter #(
  parameter int unsigned MAX_RD  = 8,
  parameter int unsigned MAX_WR  = 8,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  ariane_axi_pkg::m_req_t  axi_req_i,
  output ariane_axi_pkg::m_resp_t axi_resp_o,
  output ariane_axi_pkg::m_req_t  axi_req_o,
  input  ariane_axi_pkg::m_resp_t axi_resp_i,
  input  logic                    drain_req_i,
  output logic                    drain_ack_o,
  output logic                    idle_o,
  output logic [7:0]              rd_cnt_o,
  output logic [7:0]              wr_cnt_o,
  output logic                    timeout_o
);

  localparam logic [7:0]  LP_MAX_RD  = 8'(MAX_RD);
  localparam logic [7:0]  LP_MAX_WR  = 8'(MAX_WR);
  localparam logic [31:0] LP_TIMEOUT = 32'(TIMEOUT);

  // ST_RUN: AR/AW gated by count | ST_DRAIN: only held AR/AW may finish | ST_DRAINED: quiet, ack high
  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DRAINED} state_t;

  state_t      r_state;
  logic        r_ar_hold, r_aw_hold;
  logic [7:0]  r_rd_cnt, r_wr_cnt;
  logic [31:0] r_wd_cnt;
  logic        r_timeout, r_drain_ack;

  logic        w_ar_ok, w_aw_ok, w_ar_fwd, w_aw_fwd, w_ar_hs, w_aw_hs;
  logic        w_r_hs, w_r_last_hs, w_b_hs, w_idle, w_quiet;
  logic [31:0] w_wd_nxt;

  assign w_ar_ok     = r_ar_hold | ((r_state == ST_RUN) & (r_rd_cnt < LP_MAX_RD));
  assign w_aw_ok     = r_aw_hold | ((r_state == ST_RUN) & (r_wr_cnt < LP_MAX_WR));
  assign w_ar_fwd    = axi_req_i.ar_valid & w_ar_ok;
  assign w_aw_fwd    = axi_req_i.aw_valid & w_aw_ok;
  assign w_ar_hs     = w_ar_fwd & axi_resp_i.ar_ready;
  assign w_aw_hs     = w_aw_fwd & axi_resp_i.aw_ready;
  assign w_r_hs      = axi_resp_i.r_valid & axi_req_i.r_ready;
  assign w_r_last_hs = w_r_hs & axi_resp_i.r.last;
  assign w_b_hs      = axi_resp_i.b_valid & axi_req_i.b_ready;
  assign w_idle      = (r_rd_cnt == 8'd0) & (r_wr_cnt == 8'd0);
  assign w_quiet     = w_idle & ~r_ar_hold & ~r_aw_hold;

  always_comb begin
    axi_req_o           = axi_req_i;
    axi_req_o.ar_valid  = w_ar_fwd;
    axi_req_o.aw_valid  = w_aw_fwd;
    axi_resp_o          = axi_resp_i;
    axi_resp_o.ar_ready = axi_resp_i.ar_ready & w_ar_ok;
    axi_resp_o.aw_ready = axi_resp_i.aw_ready & w_aw_ok;
  end

  // a decrement at zero is a downstream protocol error; saturate rather than wrap
  function automatic logic [7:0] cnt_upd(input logic [7:0] cnt, input logic inc, input logic dec);
    case ({inc, dec})
      2'b10:   return cnt + 8'd1;
      2'b01:   return (cnt == 8'd0) ? cnt : cnt - 8'd1;
      default: return cnt;
    endcase
  endfunction

  always_comb begin
    w_wd_nxt = r_wd_cnt;
    if (w_r_hs | w_b_hs | w_idle) w_wd_nxt = '0;
    else if (r_wd_cnt < LP_TIMEOUT) w_wd_nxt = r_wd_cnt + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_RUN;
      r_ar_hold   <= 1'b0;
      r_aw_hold   <= 1'b0;
      r_rd_cnt    <= 8'd0;
      r_wr_cnt    <= 8'd0;
      r_wd_cnt    <= '0;
      r_timeout   <= 1'b0;
      r_drain_ack <= 1'b0;
    end else begin
      if (w_ar_hs) r_ar_hold <= 1'b0;
      else if (w_ar_fwd) r_ar_hold <= 1'b1;
      if (w_aw_hs) r_aw_hold <= 1'b0;
      else if (w_aw_fwd) r_aw_hold <= 1'b1;

      r_rd_cnt <= cnt_upd(r_rd_cnt, w_ar_hs, w_r_last_hs);
      r_wr_cnt <= cnt_upd(r_wr_cnt, w_aw_hs, w_b_hs);

      r_wd_cnt <= w_wd_nxt;
      if ((LP_TIMEOUT != 32'd0) && (w_wd_nxt == LP_TIMEOUT)) r_timeout <= 1'b1;

      case (r_state)
        ST_RUN: begin
          if (drain_req_i) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!drain_req_i) begin
            r_state <= ST_RUN;
          end else if (w_quiet) begin
            r_state     <= ST_DRAINED;
            r_drain_ack <= 1'b1;
          end
        end
        ST_DRAINED: begin
          if (!drain_req_i) begin
            r_state     <= ST_RUN;
            r_drain_ack <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_RUN;
          r_drain_ack <= 1'b0;
        end
      endcase
    end
  end

  assign drain_ack_o = r_drain_ack;
  assign idle_o      = w_idle;
  assign rd_cnt_o    = r_rd_cnt;
  assign wr_cnt_o    = r_wr_cnt;
  assign timeout_o   = r_timeout;

endmodule
